// File: rtl/dmem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - MEMOP_* : RISC-V load/store funct3 encodings carried on the op buses
//   - memop_t : type of the op buses
//   - arb_state_t : arbiter state, i.e. owner of the previous beat
//   - rd_owner_t  : requester that a pending read return belongs to
//   - run_cnt_width() : width of the run counter for a given pair of limits
// ----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef logic [2:0] memop_t;

    localparam memop_t MEMOP_B  = 3'b000;
    localparam memop_t MEMOP_H  = 3'b001;
    localparam memop_t MEMOP_W  = 3'b010;
    localparam memop_t MEMOP_BU = 3'b100;
    localparam memop_t MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_CPU_RUN = 2'd1,
        ARB_DMA_RUN = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } rd_owner_t;

    // The counter must be able to reach the larger limit; never narrower
    // than 3 bits so small limits still leave saturation headroom.
    function automatic int run_cnt_width(input int max_a, input int max_b);
        int m;
        int w;
        m = (max_a > max_b) ? max_a : max_b;
        w = $clog2(m + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the CPU data port, the DMA/loader port and the RAM port that meet
// at the arbiter.
//   modport slave  : arbiter view (takes requests, drives RAM and responses)
//   modport master : surrounding system view (CPU, DMA master, RAM)
// ----------------------------------------------------------------------------
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    // CPU data port
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    memop_t      cpu_op;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    // DMA / loader port
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    memop_t      dma_op;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;

    // Single-port RAM
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    memop_t      mem_op;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_op,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_op,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_wdata, mem_op, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_op,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_op,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_wdata, mem_op, mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_run_counter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter_run_counter
// Counts consecutive beats granted to the same owner and compares the count
// against the fairness limits.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_state          : owner of the previous beat (current arbiter state)
//   i_next_state     : owner of this cycle's beat (IDLE when no beat)
//   o_dma_hold       : DMA is mid-burst and may keep the bus over the CPU
//   o_cpu_yield      : CPU has used up its run and must yield to the DMA
// ----------------------------------------------------------------------------
module dmem_arbiter_run_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMA_MAX_BURST = 4,
    parameter int CPU_MAX_RUN   = 8,
    parameter int CNT_W         = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  arb_state_t i_state,
    input  arb_state_t i_next_state,
    output logic       o_dma_hold,
    output logic       o_cpu_yield
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DMA_LIM = CNT_W'(DMA_MAX_BURST);
    localparam logic [CNT_W-1:0] CPU_LIM = CNT_W'(CPU_MAX_RUN);

    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] w_run_cnt_next;

    // Arbiter state doubles as "owner of previous beat", so a beat continues
    // a run exactly when the next state equals the current one.
    always_comb begin
        w_run_cnt_next = '0;
        if (i_next_state == ARB_IDLE) begin
            w_run_cnt_next = '0;
        end else if (i_next_state != i_state) begin
            w_run_cnt_next = CNT_W'(1);
        end else if (r_run_cnt != CNT_MAX) begin
            w_run_cnt_next = r_run_cnt + 1'b1;
        end else begin
            w_run_cnt_next = r_run_cnt;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_run_cnt <= '0;
        end else begin
            r_run_cnt <= w_run_cnt_next;
        end
    end

    assign o_dma_hold  = (i_state == ARB_DMA_RUN) && (r_run_cnt <  DMA_LIM);
    assign o_cpu_yield = (i_state == ARB_CPU_RUN) && (r_run_cnt >= CPU_LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data RAM between the CPU data port and a DMA/loader
// master, one beat per cycle. The CPU wins contention except while a DMA
// burst is below DMA_MAX_BURST beats, or once the CPU has taken CPU_MAX_RUN
// consecutive beats. A CPU that requests but is not granted is stalled.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   io_bus           : CPU, DMA and RAM signals (dmem_arbiter_if.slave)
// Read data comes back from the RAM one cycle after the address; it is routed
// to the CPU port always and flagged to the DMA with dma_rvalid.
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMA_MAX_BURST = 4,
    parameter int CPU_MAX_RUN   = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    dmem_arbiter_if.slave  io_bus
);

    localparam int CNT_W = run_cnt_width(DMA_MAX_BURST, CPU_MAX_RUN);

    arb_state_t r_state;
    arb_state_t w_state_next;
    logic       w_cpu_gnt;
    logic       w_dma_gnt;
    logic       w_dma_hold;
    logic       w_cpu_yield;
    logic       w_cpu_rd;
    logic       w_dma_rd;
    logic       r_rd_valid;
    rd_owner_t  r_rd_owner;

    dmem_arbiter_run_counter #(
        .DMA_MAX_BURST (DMA_MAX_BURST),
        .CPU_MAX_RUN   (CPU_MAX_RUN),
        .CNT_W         (CNT_W)
    ) u_run_counter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_state      (r_state),
        .i_next_state (w_state_next),
        .o_dma_hold   (w_dma_hold),
        .o_cpu_yield  (w_cpu_yield)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants are held off during reset so no beat (and no write) escapes.
    always_comb begin
        w_cpu_gnt    = 1'b0;
        w_dma_gnt    = 1'b0;
        w_state_next = ARB_IDLE;
        if (!i_reset) begin
            if (io_bus.cpu_req && io_bus.dma_req) begin
                if (w_dma_hold || w_cpu_yield) begin
                    w_dma_gnt = 1'b1;
                end else begin
                    w_cpu_gnt = 1'b1;
                end
            end else if (io_bus.cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else if (io_bus.dma_req) begin
                w_dma_gnt = 1'b1;
            end
        end
        if (w_cpu_gnt) begin
            w_state_next = ARB_CPU_RUN;
        end else if (w_dma_gnt) begin
            w_state_next = ARB_DMA_RUN;
        end
    end

    // RAM port mux; an idle bus presents address 0 with no write.
    always_comb begin
        io_bus.mem_addr  = '0;
        io_bus.mem_wdata = '0;
        io_bus.mem_op    = MEMOP_W;
        io_bus.mem_we    = 1'b0;
        if (w_cpu_gnt) begin
            io_bus.mem_addr  = io_bus.cpu_addr;
            io_bus.mem_wdata = io_bus.cpu_wdata;
            io_bus.mem_op    = io_bus.cpu_op;
            io_bus.mem_we    = io_bus.cpu_we;
        end else if (w_dma_gnt) begin
            io_bus.mem_addr  = io_bus.dma_addr;
            io_bus.mem_wdata = io_bus.dma_wdata;
            io_bus.mem_op    = io_bus.dma_op;
            io_bus.mem_we    = io_bus.dma_we;
        end
    end

    assign w_cpu_rd = w_cpu_gnt & ~io_bus.cpu_we;
    assign w_dma_rd = w_dma_gnt & ~io_bus.dma_we;

    // Remember who owns the read data the RAM returns next cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= OWNER_CPU;
        end else begin
            r_rd_valid <= w_cpu_rd | w_dma_rd;
            if (w_cpu_rd) begin
                r_rd_owner <= OWNER_CPU;
            end else if (w_dma_rd) begin
                r_rd_owner <= OWNER_DMA;
            end
        end
    end

    assign io_bus.cpu_stall  = io_bus.cpu_req & ~w_cpu_gnt & ~i_reset;
    assign io_bus.dma_gnt    = io_bus.dma_req & w_dma_gnt;
    // Masked by reset so a read return in flight is dropped immediately.
    assign io_bus.dma_rvalid = r_rd_valid & (r_rd_owner == OWNER_DMA) & ~i_reset;
    assign io_bus.dma_rdata  = io_bus.mem_rdata;
    assign io_bus.cpu_rdata  = io_bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives the arbiter through directed scenarios followed by random traffic,
// with a RAM model on the memory port. Expected grants come from a run-length
// model of the priority rules; expected read data comes from a reference copy
// of memory contents.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .DMA_MAX_BURST (4),
        .CPU_MAX_RUN   (8)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_bus  (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // RAM: registered read, read-before-write, 256 words.
    logic [31:0] ram [0:255];
    logic        ram_fill;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            bus.mem_rdata <= '0;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr[9:2]];
        end
    end

    // Reference model: owner codes 0 = none, 1 = CPU, 2 = DMA.
    logic [31:0] ref_mem [0:255];
    int          last_owner;
    int          run_len;
    int          pend_owner;
    logic [31:0] pend_data;
    int          owner_log[$];
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check just after, then advance the model.
    task automatic step(input logic r,
                        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                        input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd);
        int owner;
        logic dma_turn;
        logic exp_we;
        logic [31:0] exp_addr;
        @(negedge clk);
        rst           = r;
        bus.cpu_req   = creq;  bus.cpu_we = cwe;  bus.cpu_addr = caddr;  bus.cpu_wdata = cwd;
        bus.cpu_op    = MEMOP_W;
        bus.dma_req   = dreq;  bus.dma_we = dwe;  bus.dma_addr = daddr;  bus.dma_wdata = dwd;
        bus.dma_op    = MEMOP_BU;
        #1;
        // read return of the previous cycle's beat
        chk("dma_rvalid", 32'(bus.dma_rvalid), 32'((pend_owner == 2) && !r));
        if (pend_owner == 2 && !r) chk("dma_rdata", bus.dma_rdata, pend_data);
        if (pend_owner == 1)       chk("cpu_rdata", bus.cpu_rdata, pend_data);
        // expected owner of this cycle's beat
        owner = 0;
        if (!r) begin
            if (creq && dreq) begin
                dma_turn = (last_owner == 2 && run_len < 4) || (last_owner == 1 && run_len >= 8);
                owner = dma_turn ? 2 : 1;
            end else if (creq) begin
                owner = 1;
            end else if (dreq) begin
                owner = 2;
            end
        end
        exp_we   = (owner == 1) ? cwe   : (owner == 2) ? dwe   : 1'b0;
        exp_addr = (owner == 1) ? caddr : (owner == 2) ? daddr : 32'h0;
        chk("dma_gnt",   32'(bus.dma_gnt),   32'(owner == 2));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(creq && owner != 1 && !r));
        chk("mem_we",    32'(bus.mem_we),    32'(exp_we));
        chk("mem_addr",  bus.mem_addr,       exp_addr);
        if (owner != 0) chk("mem_op", 32'(bus.mem_op), 32'((owner == 1) ? MEMOP_W : MEMOP_BU));
        if (exp_we)     chk("mem_wdata", bus.mem_wdata, (owner == 1) ? cwd : dwd);
        // advance model
        pend_owner = 0;
        if (r) begin
            last_owner = 0;
            run_len    = 0;
        end else begin
            if (owner == 0) begin
                last_owner = 0;
                run_len    = 0;
            end else begin
                run_len    = (owner == last_owner) ? run_len + 1 : 1;
                last_owner = owner;
                owner_log.push_back(owner);
            end
            if (owner == 1 && !cwe) begin pend_owner = 1; pend_data = ref_mem[caddr[9:2]]; end
            if (owner == 2 && !dwe) begin pend_owner = 2; pend_data = ref_mem[daddr[9:2]]; end
            if (owner == 1 && cwe) ref_mem[caddr[9:2]] = cwd;
            if (owner == 2 && dwe) ref_mem[daddr[9:2]] = dwd;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int a;
        int b;
        logic rr, cq, cw, dq, dw;
        checks = 0;  errors = 0;
        last_owner = 0;  run_len = 0;  pend_owner = 0;  pend_data = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst = 1'b1;  ram_fill = 1'b1;
        bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;  bus.cpu_op = MEMOP_W;
        bus.dma_req = 1'b0;  bus.dma_we = 1'b0;  bus.dma_addr = '0;  bus.dma_wdata = '0;  bus.dma_op = MEMOP_BU;
        @(posedge clk);
        #1 ram_fill = 1'b0;

        // Reset with both requesting: no grant, no write, no stall.
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b1, 32'h20, 32'h2222_2222);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 32'h20, 32'h0);

        // CPU only: store then load.
        step(1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'h0,         1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        chk("cpu_load_deadbeef", bus.cpu_rdata, 32'hDEAD_BEEF);

        // DMA only: three reads.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);
        idle();
        chk("dma_read_last", bus.dma_rdata, init_word(2));

        // Both requesting continuously from idle: 8 CPU beats, then 4 DMA.
        owner_log.delete();
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0, 32'(64 + i * 4), 32'h0);
        end
        for (int i = 0; i < 24; i++) begin
            chk("burst_pattern", 32'(owner_log[i]), 32'(((i % 12) < 8) ? 1 : 2));
        end
        idle();

        // DMA write then CPU read of the same word.
        step(1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0);
        idle();
        chk("cpu_sees_dma_write", bus.cpu_rdata, 32'h1234_5678);
        // Contended: CPU reads first (old data), DMA writes next, CPU rereads.
        step(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b1, 32'h44, 32'hCAFE_F00D);
        step(1'b0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h44, 32'hCAFE_F00D);
        chk("cpu_old_before_dma_write", bus.cpu_rdata, init_word(17));
        step(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0);
        idle();
        chk("cpu_new_after_dma_write", bus.cpu_rdata, 32'hCAFE_F00D);

        // Reset mid DMA burst just after a read grant.
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
        chk("rvalid_cleared_in_reset", 32'(bus.dma_rvalid), 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
        chk("post_reset_cpu_first", 32'(bus.cpu_stall), 32'h0);
        idle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rr = ($urandom_range(0, 59) == 0);
            cq = ($urandom_range(0, 2) != 0);
            dq = ($urandom_range(0, 2) != 0);
            cw = $urandom_range(0, 1) != 0;
            dw = $urandom_range(0, 1) != 0;
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            step(rr, cq, cw, 32'(a * 4), $urandom, dq, dw, 32'(b * 4), $urandom);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
